vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  Sequences the 640x480@60 Hz VGA pixel datapath. Divides the 50 MHz system clock into a
//  25 MHz pixel tick and runs the horizontal/vertical counters. Drives pix_x/pix_y to the glyph
//  block, which returns blank/letra one tick later, then emits the aligned HSYNC/VSYNC/RGB.
//  Colour configuration is accepted only in vertical blanking, so colour never changes mid-frame.
// PARAMETERS
//  CLK_DIV    2    system clocks per pixel tick (>=2)
//  H_VIS      640  visible pixels per line
//  H_FP       16   horizontal front porch, pixels
//  H_SW       96   hsync width, pixels
//  H_BP       48   horizontal back porch, pixels
//  V_VIS      480  visible lines
//  V_FP       10   vertical front porch, lines
//  V_SW       2    vsync width, lines
//  V_BP       33   vertical back porch, lines
//  SYNC_POL   0    sync active level (0 = active-low)
// PORTS
//  clk          in   1   50 MHz system clock; all logic on rising edge
//  reset        in   1   reset, synchronous, active-high
//  letra        in   1   glyph pixel from the glyph block, valid one tick after pix_x/pix_y
//  cfg_valid    in   1   colour-update request
//  cfg_fg       in   8   foreground RGB332
//  cfg_bg       in   8   background RGB332
//  cfg_ready    out  1   high while the request can be accepted (vertical blank)
//  pix_tick     out  1   one-clock strobe per pixel
//  pix_x        out  10  horizontal count 0..H_VIS+H_FP+H_SW+H_BP-1 (0..799)
//  pix_y        out  10  vertical count 0..524
//  frame_start  out  1   one-tick pulse when pix_x=0 and pix_y=0
//  hsync        out  1   horizontal sync, pipeline-aligned with rgb
//  vsync        out  1   vertical sync, pipeline-aligned with rgb
//  rgb          out  8   pixel colour RGB332
// BEHAVIOUR
//  - Reset: div counter=0, pix_x=0, pix_y=0, pix_tick=0, frame_start=0, cfg_ready=0, rgb=0,
//    hsync=vsync=~SYNC_POL, fg=8'hFF, bg=8'h00. Reset mid-frame restarts at (0,0) next clock.
//  - pix_tick is high for 1 clk every CLK_DIV clks, first time at clk CLK_DIV-1 after reset release.
//    Counters, FSMs and the output pipeline advance only on pix_tick.
//  - H FSM: H_ACT (x 0..639) -> H_FP (640..655) -> H_SYNC (656..751) -> H_BP (752..799) -> H_ACT.
//    At x=799, x wraps to 0 and the V FSM steps once.
//  - V FSM: V_ACT (y 0..479) -> V_FP (480..489) -> V_SYNC (490..491) -> V_BP (492..524) -> V_ACT.
//    At y=524 with x=799, y wraps to 0.
//  - video_on = H_ACT & V_ACT (internal). Sync is asserted while the FSM is in its SYNC state.
//  - Pipeline: stage 1 registers video_on, hsync and vsync for one tick. Stage 2 drives the outputs:
//    rgb = d_video_on ? (letra ? fg : bg) : 8'h00. hsync/vsync lag pix_x/pix_y by 2 ticks,
//    matching rgb. Total latency pix_x -> rgb = 2 ticks.
//  - Config handshake: cfg_ready = V_FP|V_SYNC|V_BP, excluding the final tick (y=524, x=799).
//    Transfer occurs on cfg_valid & cfg_ready & pix_tick, loading shadow fg/bg.
//    Shadow registers copy to active fg/bg on the frame_start tick.
//    Requests while cfg_ready=0 wait (requester holds cfg_valid). Multiple transfers in one
//    blank: last wins.
//  - Width rules: counters are 10-bit unsigned, wrap exactly at the totals with no overflow.
//    The sum of the parameters must be < 1024.
// STRUCTURE
//  - Shared package vga_pkg: timing constants (defaults above), H/V state encodings
//    (2-bit: ACT, FP, SYNC, BP), RGB332 typedef.
//  - One sub-module vga_axis_fsm (parameters VIS/FP/SW/BP), instantiated for H and V.
//    Ports: clk, reset, step, count, state, wrap.
//  - Top level holds: divider, pipeline, colour shadow/active registers, rgb mux.
// TESTING
//  1. Reset held 3 clks, then released -> pix_tick at clk 1,3,5...; pix_x 0,1,2; hsync=1, vsync=1, rgb=0.
//  2. Free-run one line -> hsync low for exactly 96 ticks, first low at output tick for x=656
//     (2 ticks late); line = 800 ticks.
//  3. Free-run one frame -> vsync low for 2 lines (1600 ticks); frame = 420000 ticks;
//     one frame_start per frame.
//  4. letra=1 at x=10..17, y=5; fg=FF, bg=00 -> rgb=FF for those 8 ticks (2-tick delay);
//     rgb=0 in all blanking regardless of letra.
//  5. cfg_valid with fg=E0, bg=03 at y=100 -> cfg_ready=0, no transfer; at y=480 transfer;
//     rgb uses E0/03 from the next frame_start, not before.
//  6. Assert reset at x=300, y=200 for 1 clk -> next clk pix_x=0, pix_y=0, colours back to FF/00,
//     pending shadow discarded.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, axis state encoding and colour type for the VGA timing slice.
package vga_pkg;

    localparam int unsigned CNT_W       = 10;

    localparam int unsigned DEF_CLK_DIV = 2;
    localparam int unsigned DEF_H_VIS   = 640;
    localparam int unsigned DEF_H_FP    = 16;
    localparam int unsigned DEF_H_SW    = 96;
    localparam int unsigned DEF_H_BP    = 48;
    localparam int unsigned DEF_V_VIS   = 480;
    localparam int unsigned DEF_V_FP    = 10;
    localparam int unsigned DEF_V_SW    = 2;
    localparam int unsigned DEF_V_BP    = 33;

    typedef enum logic [1:0] {
        ST_ACT  = 2'd0,
        ST_FP   = 2'd1,
        ST_SYNC = 2'd2,
        ST_BP   = 2'd3
    } axis_state_t;

    typedef logic [7:0] rgb332_t;

    localparam rgb332_t RGB_WHITE = 8'hFF;
    localparam rgb332_t RGB_BLACK = 8'h00;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Colour-configuration handshake between a requester and the VGA timing controller.
interface vga_timing_ctrl_if;
    import vga_pkg::*;

    logic    cfg_valid;
    rgb332_t cfg_fg;
    rgb332_t cfg_bg;
    logic    cfg_ready;

    modport master (output cfg_valid, output cfg_fg, output cfg_bg, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_fg, input  cfg_bg, output cfg_ready);

endinterface

// File: rtl/vga_axis_fsm.sv
// One scan axis: counter plus ACT/FP/SYNC/BP state machine, advancing once per step.
module vga_axis_fsm
    import vga_pkg::*;
#(
    parameter int unsigned VIS = DEF_H_VIS,
    parameter int unsigned FP  = DEF_H_FP,
    parameter int unsigned SW  = DEF_H_SW,
    parameter int unsigned BP  = DEF_H_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output axis_state_t      state,
    output logic             wrap
);

    localparam int unsigned TOTAL = VIS + FP + SW + BP;

    localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(VIS - 1);
    localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(VIS + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(VIS + FP + SW - 1);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);

    axis_state_t state_nxt;

    assign wrap = step && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ACT;
            count <= '0;
        end else if (step) begin
            state <= state_nxt;
            count <= wrap ? '0 : count + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACT:  if (count == LAST_ACT)  state_nxt = ST_FP;
            ST_FP:   if (count == LAST_FP)   state_nxt = ST_SYNC;
            ST_SYNC: if (count == LAST_SYNC) state_nxt = ST_BP;
            ST_BP:   if (count == LAST)      state_nxt = ST_ACT;
            default: state_nxt = ST_ACT;
        endcase
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel-tick divider, H/V scan FSMs, two-stage sync/colour pipeline,
// and colour shadow registers that only take effect at the start of a frame.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned H_VIS    = DEF_H_VIS,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SW     = DEF_H_SW,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_VIS    = DEF_V_VIS,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SW     = DEF_V_SW,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              letra,
    vga_timing_ctrl_if.slave  cfg,
    output logic              pix_tick,
    output logic [CNT_W-1:0]  pix_x,
    output logic [CNT_W-1:0]  pix_y,
    output logic              frame_start,
    output logic              hsync,
    output logic              vsync,
    output rgb332_t           rgb
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SW + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_cnt;
    axis_state_t      h_state;
    axis_state_t      v_state;
    logic             h_wrap;
    logic             v_wrap;
    logic             at_origin;
    logic             cfg_ready_int;
    logic             xfer;
    logic             video_on;
    logic             d_video_on;
    logic             d_hs;
    logic             d_vs;
    rgb332_t          sh_fg, sh_bg;
    rgb332_t          fg, bg;

    always_ff @(posedge clk) begin
        if (reset || pix_tick) div_cnt <= '0;
        else                   div_cnt <= div_cnt + 1'b1;
    end

    assign pix_tick = (div_cnt == DIV_LAST);

    vga_axis_fsm #(.VIS(H_VIS), .FP(H_FP), .SW(H_SW), .BP(H_BP)) u_h_axis (
        .clk   (clk),
        .reset (reset),
        .step  (pix_tick),
        .count (pix_x),
        .state (h_state),
        .wrap  (h_wrap)
    );

    vga_axis_fsm #(.VIS(V_VIS), .FP(V_FP), .SW(V_SW), .BP(V_BP)) u_v_axis (
        .clk   (clk),
        .reset (reset),
        .step  (h_wrap),
        .count (pix_y),
        .state (v_state),
        .wrap  (v_wrap)
    );

    // at_origin tracks (0,0) so frame_start needs no 20-bit compare.
    always_ff @(posedge clk) begin
        if (reset)         at_origin <= 1'b1;
        else if (pix_tick) at_origin <= v_wrap;
    end

    assign frame_start   = pix_tick && at_origin;
    assign cfg_ready_int = (v_state != ST_ACT) && !((pix_x == H_LAST) && (pix_y == V_LAST));
    assign cfg.cfg_ready = cfg_ready_int;
    assign xfer          = cfg.cfg_valid && cfg_ready_int && pix_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_fg <= RGB_WHITE;
            sh_bg <= RGB_BLACK;
            fg    <= RGB_WHITE;
            bg    <= RGB_BLACK;
        end else begin
            if (xfer) begin
                sh_fg <= cfg.cfg_fg;
                sh_bg <= cfg.cfg_bg;
            end
            if (frame_start) begin
                fg <= sh_fg;
                bg <= sh_bg;
            end
        end
    end

    assign video_on = (h_state == ST_ACT) && (v_state == ST_ACT);

    // Stage 1 waits for the glyph lookup; stage 2 emits colour and sync together.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_video_on <= 1'b0;
            d_hs       <= ~SYNC_POL;
            d_vs       <= ~SYNC_POL;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            rgb        <= '0;
        end else if (pix_tick) begin
            d_video_on <= video_on;
            d_hs       <= (h_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            d_vs       <= (v_state == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            hsync      <= d_hs;
            vsync      <= d_vs;
            rgb        <= d_video_on ? (letra ? fg : bg) : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a reduced 35x19 raster so whole frames stay short.
module tb_vga_timing_ctrl;
    import vga_pkg::*;

    localparam int unsigned HV = 20, HF = 4, HS = 6, HB = 5;
    localparam int unsigned VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int unsigned HT = HV + HF + HS + HB;
    localparam int unsigned VT = VV + VF + VS + VB;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       letra = 1'b0;
    logic       pix_tick;
    logic [9:0] pix_x, pix_y;
    logic       frame_start, hsync, vsync;
    rgb332_t    rgb;

    vga_timing_ctrl_if cfg_if ();

    vga_timing_ctrl #(
        .CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .letra       (letra),
        .cfg         (cfg_if.slave),
        .pix_tick    (pix_tick),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb)
    );

    always #5 clk = ~clk;

    // Glyph block stand-in: registered lookup, one tick behind pix_x/pix_y.
    always @(posedge clk)
        if (pix_tick) letra <= (pix_y == 10'd5) && (pix_x >= 10'd10) && (pix_x <= 10'd17);

    int fs_cnt = 0;
    always @(negedge clk) if (frame_start) fs_cnt++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (pix_tick) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic advance(input int x, input int y, output bit ok);
        bit t;
        ok = 1'b0;
        for (int i = 0; i < 2 * HT * VT; i++) begin
            next_tick(t);
            if (!t) return;
            if (int'(pix_x) == x && int'(pix_y) == y) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check({tag, " x"},     32'(pix_x), 32'd0);
        check({tag, " y"},     32'(pix_y), 32'd0);
        check({tag, " rgb"},   32'(rgb), 32'h00);
        check({tag, " hsync"}, 32'(hsync), 32'd1);
        check({tag, " vsync"}, 32'(vsync), 32'd1);
        check({tag, " rdy"},   32'(cfg_if.cfg_ready), 32'd0);
    endtask

    typedef struct {
        int      x;
        int      y;
        logic    cv;
        rgb332_t fg;
        rgb332_t bg;
        rgb332_t e_rgb;
        logic    e_hs;
        logic    e_vs;
        logic    e_rdy;
    } vec_t;

    function automatic vec_t mk(input int x, input int y, input logic cv, input rgb332_t fg,
                                input rgb332_t bg, input rgb332_t er, input logic hs,
                                input logic vs, input logic rdy);
        vec_t v;
        v.x = x; v.y = y; v.cv = cv; v.fg = fg; v.bg = bg;
        v.e_rgb = er; v.e_hs = hs; v.e_vs = vs; v.e_rdy = rdy;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int e_tick[5] = '{0, 1, 0, 1, 0};
        int e_px[5]   = '{0, 0, 1, 1, 2};
        int e_fs[5]   = '{0, 1, 0, 0, 0};
        int fs0, hs_lo, vs_lo, maxx, maxy;

        // Observed at (x,y) after the tick edge; outputs show pixel (x-2,y).
        // Frame A (FF/00 active), request E0/03 held from active video until blanking.
        vecs.push_back(mk( 5,  0, 1, 8'hE0, 8'h03, 8'h00, 1, 1, 0));
        vecs.push_back(mk(12,  5, 1, 8'hE0, 8'h03, 8'hFF, 1, 1, 0));
        vecs.push_back(mk(19,  5, 1, 8'hE0, 8'h03, 8'hFF, 1, 1, 0));
        vecs.push_back(mk(20,  5, 1, 8'hE0, 8'h03, 8'h00, 1, 1, 0));
        vecs.push_back(mk(22,  6, 1, 8'hE0, 8'h03, 8'h00, 1, 1, 0));
        vecs.push_back(mk(25,  6, 1, 8'hE0, 8'h03, 8'h00, 1, 1, 0));
        vecs.push_back(mk(26,  6, 1, 8'hE0, 8'h03, 8'h00, 0, 1, 0));
        vecs.push_back(mk(31,  6, 1, 8'hE0, 8'h03, 8'h00, 0, 1, 0));
        vecs.push_back(mk(32,  6, 1, 8'hE0, 8'h03, 8'h00, 1, 1, 0));
        vecs.push_back(mk( 2, 12, 1, 8'hE0, 8'h03, 8'h00, 1, 1, 1));
        vecs.push_back(mk( 1, 14, 0, 8'h00, 8'h00, 8'h00, 1, 1, 1));
        vecs.push_back(mk( 2, 14, 0, 8'h00, 8'h00, 8'h00, 1, 0, 1));
        vecs.push_back(mk(33, 18, 0, 8'h00, 8'h00, 8'h00, 1, 1, 1));
        vecs.push_back(mk(34, 18, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0));
        // Frame B (E0/03); two back-to-back transfers in blanking, the second must win.
        vecs.push_back(mk( 0,  0, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0));
        vecs.push_back(mk( 2,  0, 0, 8'h00, 8'h00, 8'h03, 1, 1, 0));
        vecs.push_back(mk(12,  5, 0, 8'h00, 8'h00, 8'hE0, 1, 1, 0));
        vecs.push_back(mk(20,  5, 0, 8'h00, 8'h00, 8'h03, 1, 1, 0));
        vecs.push_back(mk(22,  5, 0, 8'h00, 8'h00, 8'h00, 1, 1, 0));
        vecs.push_back(mk( 0, 16, 1, 8'h1C, 8'hE3, 8'h00, 1, 0, 1));
        vecs.push_back(mk( 1, 16, 1, 8'h92, 8'h49, 8'h00, 1, 0, 1));
        vecs.push_back(mk( 2, 16, 0, 8'h00, 8'h00, 8'h00, 1, 1, 1));
        // Frame C (92/49); leave 1C/E3 pending in the shadow before the reset below.
        vecs.push_back(mk( 2,  0, 0, 8'h00, 8'h00, 8'h49, 1, 1, 0));
        vecs.push_back(mk(12,  5, 0, 8'h00, 8'h00, 8'h92, 1, 1, 0));
        vecs.push_back(mk(19,  5, 0, 8'h00, 8'h00, 8'h92, 1, 1, 0));
        vecs.push_back(mk(21,  5, 0, 8'h00, 8'h00, 8'h49, 1, 1, 0));
        vecs.push_back(mk( 0, 17, 1, 8'h1C, 8'hE3, 8'h00, 1, 1, 1));
        vecs.push_back(mk( 3, 17, 0, 8'h00, 8'h00, 8'h00, 1, 1, 1));

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_fg    = 8'h00;
        cfg_if.cfg_bg    = 8'h00;

        // Reset held three clocks, then the first ticks after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst pix_tick", 32'(pix_tick), 32'd0);
        check("rst frame_start", 32'(frame_start), 32'd0);
        check("rst x", 32'(pix_x), 32'd0);
        check("rst y", 32'(pix_y), 32'd0);
        check("rst hsync", 32'(hsync), 32'd1);
        check("rst vsync", 32'(vsync), 32'd1);
        check("rst rgb", 32'(rgb), 32'h00);
        check("rst rdy", 32'(cfg_if.cfg_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("start clk%0d tick", k), 32'(pix_tick), 32'(e_tick[k]));
            check($sformatf("start clk%0d x", k), 32'(pix_x), 32'(e_px[k]));
            check($sformatf("start clk%0d fs", k), 32'(frame_start), 32'(e_fs[k]));
        end

        foreach (vecs[i]) begin
            advance(vecs[i].x, vecs[i].y, ok);
            check($sformatf("v%0d reach", i), 32'(ok), 32'd1);
            cfg_if.cfg_valid = vecs[i].cv;
            cfg_if.cfg_fg    = vecs[i].fg;
            cfg_if.cfg_bg    = vecs[i].bg;
            check($sformatf("v%0d rgb", i),   32'(rgb), 32'(vecs[i].e_rgb));
            check($sformatf("v%0d hsync", i), 32'(hsync), 32'(vecs[i].e_hs));
            check($sformatf("v%0d vsync", i), 32'(vsync), 32'(vecs[i].e_vs));
            check($sformatf("v%0d rdy", i),   32'(cfg_if.cfg_ready), 32'(vecs[i].e_rdy));
        end

        // Reset in blanking with 1C/E3 pending: colours must return to FF/00.
        pulse_reset("rstA");
        advance(2, 0, ok);
        check("rstA reach bg", 32'(ok), 32'd1);
        check("rstA bg", 32'(rgb), 32'h00);
        advance(12, 5, ok);
        check("rstA reach fg", 32'(ok), 32'd1);
        check("rstA fg", 32'(rgb), 32'hFF);

        // Reset mid-active video.
        advance(17, 6, ok);
        check("rstB reach", 32'(ok), 32'd1);
        pulse_reset("rstB");

        // One full frame from the origin.
        fs0 = fs_cnt; hs_lo = 0; vs_lo = 0; maxx = 0; maxy = 0;
        for (int i = 0; i < int'(HT * VT); i++) begin
            next_tick(ok);
            if (!ok) begin
                check("frame tick timeout", 32'd0, 32'd1);
                break;
            end
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (int'(pix_x) > maxx) maxx = int'(pix_x);
            if (int'(pix_y) > maxy) maxy = int'(pix_y);
        end
        check("frame end x", 32'(pix_x), 32'd0);
        check("frame end y", 32'(pix_y), 32'd0);
        check("frame max x", 32'(maxx), 32'(HT - 1));
        check("frame max y", 32'(maxy), 32'(VT - 1));
        check("frame hsync low ticks", 32'(hs_lo), 32'(HS * VT));
        check("frame vsync low ticks", 32'(vs_lo), 32'(VS * HT));
        check("frame_start per frame", 32'(fs_cnt - fs0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
